// File: rtl/mem_stage_dmem_if.sv
// Bus between the EX/MEM register, the MEM-stage data memory and the MEM/WB register.
// The master side drives the access request; the slave side is the data memory.
interface mem_stage_dmem_if;
  logic [31:0] Alu_Result_mem;
  logic [31:0] di_mem;
  logic        rmem;
  logic        wmem;
  logic [1:0]  msize;
  logic        msign;
  logic        fault_clr;
  logic [31:0] mo_mem;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_store;

  modport master (
    output Alu_Result_mem, di_mem, rmem, wmem, msize, msign, fault_clr,
    input  mo_mem, fault, fault_addr, fault_store
  );

  modport slave (
    input  Alu_Result_mem, di_mem, rmem, wmem, msize, msign, fault_clr,
    output mo_mem, fault, fault_addr, fault_store
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: little-endian byte/half/word loads and stores with
// sign/zero extension, combinational read and a sticky misalignment fault register.
module mem_stage_dmem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic           Clock,
  input  logic           Resetn,
  mem_stage_dmem_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           addr;
  logic [DEPTH_LOG2-1:0] idx;
  size_e                 size;
  logic                  misaligned;
  logic                  fault_evt;
  logic [31:0]           cur_word;
  logic [31:0]           wr_word;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_data;
  logic                  fault_q;
  logic [31:0]           fault_addr_q;
  logic                  fault_store_q;
  logic                  unused_addr;

  assign addr        = bus.Alu_Result_mem;
  assign idx         = addr[DEPTH_LOG2+1:2];
  assign size        = size_e'(bus.msize);
  // Upper address bits alias the memory; they are intentionally dropped.
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign misaligned = (size == SZ_HALF && addr[0])
                   || (size == SZ_WORD && addr[1:0] != 2'b00)
                   || (size == SZ_BAD);
  assign fault_evt  = (bus.rmem || bus.wmem) && misaligned;

  assign cur_word  = mem[idx];
  assign byte_lane = cur_word[{addr[1:0], 3'b000} +: 8];
  assign half_lane = cur_word[{addr[1], 4'b0000} +: 16];

  // Merge the store data into the addressed lane(s) of the current word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_word = cur_word;
    unique case (size)
      SZ_BYTE: wr_word[{addr[1:0], 3'b000} +: 8]  = bus.di_mem[7:0];
      SZ_HALF: wr_word[{addr[1], 4'b0000} +: 16]  = bus.di_mem[15:0];
      SZ_WORD: wr_word                            = bus.di_mem;
      SZ_BAD:  wr_word                            = cur_word;
    endcase
  end

  // Reads see the array before this edge's write, giving read-before-write.
  always_comb begin
    load_data = '0;
    if (bus.rmem && !misaligned) begin
      unique case (size)
        SZ_BYTE: load_data = {{24{bus.msign & byte_lane[7]}}, byte_lane};
        SZ_HALF: load_data = {{16{bus.msign & half_lane[15]}}, half_lane};
        SZ_WORD: load_data = cur_word;
        SZ_BAD:  load_data = '0;
      endcase
    end
  end

  // NOTE: the array is cleared on reset because software relies on zeroed data memory after Resetn.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        mem[i] <= '0;
      end
    end else if (bus.wmem && !misaligned) begin
      mem[idx] <= wr_word;
    end
  end

  // First fault wins while set; a new fault on a clearing edge is still captured.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_store_q <= 1'b0;
    end else if (fault_evt && (!fault_q || bus.fault_clr)) begin
      fault_q       <= 1'b1;
      fault_addr_q  <= addr;
      fault_store_q <= bus.wmem;
    end else if (bus.fault_clr) begin
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_store_q <= 1'b0;
    end
  end

  assign bus.mo_mem      = load_data;
  assign bus.fault       = fault_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.fault_store = fault_store_q;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: expected load data is queued when a cycle is
// driven and popped when the combinational output is sampled mid-cycle.
module tb_mem_stage_dmem;
  logic Clock;
  logic Resetn;

  mem_stage_dmem_if bus ();

  mem_stage_dmem #(.DEPTH_LOG2(10)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Alu_Result_mem = '0;
    bus.di_mem         = '0;
    bus.rmem           = 1'b0;
    bus.wmem           = 1'b0;
    bus.msize          = 2'b10;
    bus.msign          = 1'b0;
    bus.fault_clr      = 1'b0;
  endtask

  // Drive one access for a full cycle; mo_mem is sampled on the falling edge.
  task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic r, input logic w, input logic [1:0] sz,
                     input logic sg, input logic clr, input logic [31:0] exp_mo);
    exp_t e;
    bus.Alu_Result_mem = a;
    bus.di_mem         = d;
    bus.rmem           = r;
    bus.wmem           = w;
    bus.msize          = sz;
    bus.msign          = sg;
    bus.fault_clr      = clr;
    e.tag = tag;
    e.val = exp_mo;
    sb.push_back(e);
    @(negedge Clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check(e.tag, bus.mo_mem, e.val);
    end
    @(posedge Clock);
    #1;
    idle_inputs();
  endtask

  task automatic check_fault(input string tag, input logic f, input logic [31:0] fa,
                             input logic fs);
    check({tag, "_fault"},       {31'b0, bus.fault},       {31'b0, f});
    check({tag, "_fault_addr"},  bus.fault_addr,           fa);
    check({tag, "_fault_store"}, {31'b0, bus.fault_store}, {31'b0, fs});
  endtask

  initial begin
    idle_inputs();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;

    // Reset state
    check_fault("reset", 1'b0, 32'h0, 1'b0);
    cyc("rst_load_w0", 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0000);

    // Word store then narrow loads with both extensions
    cyc("st_w10",      32'h10, 32'h8899_AABB, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("ld_b11_s",    32'h11, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFAA);
    cyc("ld_b11_u",    32'h11, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00AA);
    cyc("ld_h12_s",    32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'hFFFF_8899);
    cyc("ld_h10_s",    32'h10, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'hFFFF_AABB);
    cyc("ld_b10_s",    32'h10, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFBB);
    cyc("ld_b13_u",    32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0088);
    cyc("ld_w10_sign", 32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h8899_AABB);

    // Narrow stores only touch their lanes
    cyc("st_b13",      32'h13, 32'hFFFF_FF5A, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    cyc("ld_w10_b",    32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h5A99_AABB);
    cyc("st_h10",      32'h10, 32'hABCD_1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    cyc("ld_w10_h",    32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h5A99_1234);
    cyc("st_h12",      32'h12, 32'h0000_7766, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    cyc("ld_w10_h2",   32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h7766_1234);

    // Misaligned store: memory unchanged, fault captured
    cyc("st_w20",      32'h20, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    check_fault("pre_fault", 1'b0, 32'h0, 1'b0);
    cyc("st_w22_mis",  32'h22, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    check_fault("mis_st22", 1'b1, 32'h22, 1'b1);
    cyc("ld_w20_keep", 32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Second fault ignored; misaligned load returns zero
    cyc("ld_h31_mis",  32'h31, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    check_fault("first_wins", 1'b1, 32'h22, 1'b1);

    // Set wins over clear
    cyc("ld_w41_clr",  32'h41, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0);
    check_fault("set_over_clr", 1'b1, 32'h41, 1'b0);
    cyc("clr_only",    32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0);
    check_fault("cleared", 1'b0, 32'h0, 1'b0);

    // Illegal size faults even at an aligned address; no request means no fault
    cyc("idle_mis",    32'h23, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    check_fault("no_request", 1'b0, 32'h0, 1'b0);
    cyc("ld_sz11",     32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
    check_fault("size11", 1'b1, 32'h10, 1'b0);
    cyc("clr_again",   32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0);

    // Read-before-write, then new data visible next cycle
    cyc("st_w10_old",  32'h10, 32'h1111_1111, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("rw_w10",      32'h10, 32'h2222_2222, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h1111_1111);
    cyc("ld_w10_new",  32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h2222_2222);

    // Aliasing modulo 4 KB
    cyc("st_w1004",    32'h1004, 32'h600D_D00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("ld_w4_alias", 32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h600D_D00D);
    cyc("st_h2_mis",   32'h3, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    check_fault("pre_reset", 1'b1, 32'h3, 1'b1);

    // Asynchronous reset mid-sequence, with a store held across the reset edge
    #2;
    bus.Alu_Result_mem = 32'h8;
    bus.di_mem         = 32'hBAD0_BAD0;
    bus.wmem           = 1'b1;
    Resetn             = 1'b0;
    #1;
    check_fault("async_reset", 1'b0, 32'h0, 1'b0);
    @(posedge Clock);
    #1;
    idle_inputs();
    Resetn = 1'b1;
    cyc("post_rst_w4",  32'h4,  32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("post_rst_w10", 32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("post_rst_w20", 32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    cyc("lost_store_8", 32'h8,  32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
- Data-memory block of the MEM stage in the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register; its `mo_mem` output feeds the MEM/WB register's `mo_mem` input.
- Performs byte, halfword and word loads and stores, little-endian, with sign or zero extension on loads.
- Detects misaligned accesses and records the first one in a sticky fault register.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).

Ports:
- Clock  input  1  pipeline clock, rising edge.
- Resetn  input  1  reset; asynchronous, active-low.
- Alu_Result_mem  input  32  byte address from the EX/MEM register.
- di_mem  input  32  store data; the low byte/half is used for narrow stores.
- rmem  input  1  load request this cycle.
- wmem  input  1  store request this cycle.
- msize  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- msign  input  1  1 = sign-extend narrow loads, 0 = zero-extend.
- fault_clr  input  1  clears the sticky fault register.
- mo_mem  output  32  load data, combinational, to the MEM/WB register.
- fault  output  1  sticky misalignment flag.
- fault_addr  output  32  address of the first captured fault.
- fault_store  output  1  1 = captured fault was a store, 0 = load.

Behaviour:
Storage and addressing:
- Storage is a register array of 2^DEPTH_LOG2 x 32.
- Word index = Alu_Result_mem[DEPTH_LOG2+1:2].
- Upper address bits are ignored, so addresses alias modulo the memory size.

Byte lanes (little-endian):
- Byte lane k = bits [8k+7:8k] for addr[1:0] = k.
- Half lane: addr[1] = 0 selects bits [15:0]; addr[1] = 1 selects bits [31:16].

Alignment:
- Misaligned when (msize = 01 and addr[0] = 1), (msize = 10 and addr[1:0] != 0), or msize = 11.
- An access is a request with rmem or wmem high.

Load path (combinational, zero latency):
- rmem = 0 -> mo_mem = 0.
- Aligned load -> the selected lane, extended to 32 bits per msign.
- Word loads ignore msign.
- Misaligned load -> mo_mem = 0.

Store path:
- Written on the rising Clock edge when wmem = 1 and the access is aligned.
- Only the addressed lane(s) change; the other bytes are preserved.
- A misaligned store writes nothing.

Read/write interaction:
- rmem and wmem both high in the same cycle -> the store proceeds, and mo_mem shows the pre-write contents (read-before-write).
- A load in the cycle after a store to the same word returns the new data.

Fault register:
- On a rising edge with a misaligned access:
  - If fault = 0: fault <= 1, fault_addr <= Alu_Result_mem, fault_store <= wmem.
  - If fault = 1: first fault wins; later faults are ignored.
- fault_clr = 1 on an edge clears fault, fault_addr and fault_store to 0.
- fault_clr together with a new misaligned access on the same edge -> the new fault is captured (set wins over clear).

Reset:
- Resetn low asynchronously clears every memory word, fault, fault_addr and fault_store to 0.
- mo_mem therefore reads 0.
- A store coincident with reset assertion is lost.
- Reset mid-operation discards all memory contents.

Test Plan:
- Reset, then load word at 0x0 -> mo_mem = 0x00000000; fault = 0.
- Store word 0x8899AABB at 0x10; next cycle load byte at 0x11 with msign = 1 -> 0xFFFFFFAA; with msign = 0 -> 0x000000AA; load half at 0x12 with msign = 1 -> 0xFFFF8899.
- After the previous test, store byte 0x5A at 0x13 -> word load at 0x10 = 0x5A99AABB; store half 0x1234 at 0x10 -> word load = 0x5A991234.
- Store word at 0x22 (misaligned) -> memory unchanged, fault = 1, fault_addr = 0x22, fault_store = 1.
  - Then a load half at 0x31 -> mo_mem = 0 and fault_addr stays 0x22.
  - fault_clr together with a misaligned load at 0x41 -> fault = 1, fault_addr = 0x41, fault_store = 0.
- rmem = wmem = 1 at 0x10 with old word 0x11111111 and di_mem 0x22222222 -> mo_mem = 0x11111111 in that cycle and 0x22222222 in the next.
- With DEPTH_LOG2 = 10, store word to 0x1004 -> a load at 0x4 returns the stored value (aliasing). Assert Resetn mid-sequence -> all loads return 0 and fault = 0.
